// File: rtl/mem_req_arbiter_pkg.sv
// Shared types and constants for the inst/data memory-port arbiter.
package mem_req_arbiter_pkg;

  localparam logic OWNER_INST = 1'b0;
  localparam logic OWNER_DATA = 1'b1;

  localparam logic [1:0] SIZE_B = 2'd0;
  localparam logic [1:0] SIZE_H = 2'd1;
  localparam logic [1:0] SIZE_W = 2'd2;

  // wr + size + wstrb + addr + wdata
  localparam int REQ_W = 1 + 2 + 4 + 32 + 32;

  typedef struct packed {
    logic        wr;
    logic [1:0]  size;
    logic [3:0]  wstrb;
    logic [31:0] addr;
    logic [31:0] wdata;
  } sram_req_t;

endpackage

// File: rtl/mem_req_arbiter_owner_fifo.sv
// In-order tracker of accepted requests: one {owner, discard} entry per
// outstanding request, with a bulk "discard every inst entry" operation.
module owner_fifo
  import mem_req_arbiter_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             push_owner,
  input  logic             push_discard,
  input  logic             pop,
  input  logic             cancel_inst,
  output logic             head_owner,
  output logic             head_discard,
  output logic [PTR_W:0]   count,
  output logic             full,
  output logic             empty
);

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q,  count_d;
  logic [DEPTH-1:0] owner_q,  owner_d;
  logic [DEPTH-1:0] discard_q, discard_d;
  logic [PTR_W-1:0] offset;
  logic             do_push, do_pop;

  assign full         = (count_q == (PTR_W+1)'(DEPTH));
  assign empty        = (count_q == '0);
  assign count        = count_q;
  assign head_owner   = owner_q[rd_ptr_q];
  assign head_discard = discard_q[rd_ptr_q];
  assign do_push      = push & ~full;
  assign do_pop       = pop & ~empty;

  always_comb begin
    // NOTE: every *_d gets its hold value first so no branch can leave one
    // unassigned and infer a latch.
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    owner_d   = owner_q;
    discard_d = discard_q;
    offset    = '0;

    // An entry is live when its distance from the head is below the count.
    if (cancel_inst) begin
      for (int i = 0; i < DEPTH; i++) begin
        offset = PTR_W'(i) - rd_ptr_q;
        if (({1'b0, offset} < count_q) && (owner_q[i] == OWNER_INST)) begin
          discard_d[i] = 1'b1;
        end
      end
    end

    if (do_push) begin
      owner_d[wr_ptr_q]   = push_owner;
      discard_d[wr_ptr_q] = push_discard;
      wr_ptr_d            = wr_ptr_q + PTR_W'(1);
    end

    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end

    case ({do_push, do_pop})
      2'b10:   count_d = count_q + (PTR_W+1)'(1);
      2'b01:   count_d = count_q - (PTR_W+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    if (reset) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      discard_q <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      discard_q <= discard_d;
    end
  end

  // NOTE: owner bits are plain storage; liveness comes from the pointers,
  // so this array is deliberately left without a reset.
  always_ff @(posedge clk) begin
    owner_q <= owner_d;
  end

endmodule

// File: rtl/mem_req_arbiter.sv
// Shares one like-SRAM port between fetch (inst) and EXE (data), steering
// each response back to its owner and absorbing responses of cancelled fetches.
module mem_req_arbiter
  import mem_req_arbiter_pkg::*;
#(
  parameter int   DEPTH     = 4,
  parameter int   PTR_W     = 2,
  parameter logic DATA_PRIO = 1'b1
) (
  input  logic             clk,
  input  logic             reset,

  input  logic             inst_req,
  input  logic             inst_wr,
  input  logic [1:0]       inst_size,
  input  logic [3:0]       inst_wstrb,
  input  logic [31:0]      inst_addr,
  input  logic [31:0]      inst_wdata,
  output logic             inst_addr_ok,
  output logic             inst_data_ok,
  output logic [31:0]      inst_rdata,
  input  logic             inst_cancel,

  input  logic             data_req,
  input  logic             data_wr,
  input  logic [1:0]       data_size,
  input  logic [3:0]       data_wstrb,
  input  logic [31:0]      data_addr,
  input  logic [31:0]      data_wdata,
  output logic             data_addr_ok,
  output logic             data_data_ok,
  output logic [31:0]      data_rdata,

  output logic             mem_req,
  output logic             mem_wr,
  output logic [1:0]       mem_size,
  output logic [3:0]       mem_wstrb,
  output logic [31:0]      mem_addr,
  output logic [31:0]      mem_wdata,
  input  logic             mem_addr_ok,
  input  logic             mem_data_ok,
  input  logic [31:0]      mem_rdata,

  output logic [PTR_W:0]   outstanding,
  output logic             proto_err
);

  sram_req_t        inst_bundle, data_bundle;
  logic [REQ_W-1:0] mem_bundle;
  logic             gnt_data, gnt_inst;
  logic             fifo_full, fifo_empty;
  logic             head_owner, head_discard;
  logic             push, pop, push_owner, push_discard;
  logic             proto_err_q, proto_err_d;

  assign inst_bundle = '{wr: inst_wr, size: inst_size, wstrb: inst_wstrb,
                         addr: inst_addr, wdata: inst_wdata};
  assign data_bundle = '{wr: data_wr, size: data_size, wstrb: data_wstrb,
                         addr: data_addr, wdata: data_wdata};

  always_comb begin
    gnt_data = data_req & (DATA_PRIO | ~inst_req);
    gnt_inst = inst_req & ~gnt_data;

    // A pop in the same cycle does not free a slot for issue.
    mem_req  = (inst_req | data_req) & ~fifo_full;

    mem_bundle = '0;
    if (gnt_data) begin
      mem_bundle = data_bundle;
    end else if (gnt_inst) begin
      mem_bundle = inst_bundle;
    end

    inst_addr_ok = mem_addr_ok & mem_req & gnt_inst;
    data_addr_ok = mem_addr_ok & mem_req & gnt_data;

    push         = mem_req & mem_addr_ok;
    push_owner   = gnt_data ? OWNER_DATA : OWNER_INST;
    push_discard = inst_cancel & gnt_inst;

    // Responses route on the head entry as it stood before any cancel.
    pop          = mem_data_ok & ~fifo_empty;
    inst_data_ok = pop & (head_owner == OWNER_INST) & ~head_discard;
    data_data_ok = pop & (head_owner == OWNER_DATA);
    inst_rdata   = inst_data_ok ? mem_rdata : '0;
    data_rdata   = data_data_ok ? mem_rdata : '0;

    proto_err_d  = proto_err_q | (mem_data_ok & fifo_empty);
  end

  assign {mem_wr, mem_size, mem_wstrb, mem_addr, mem_wdata} = mem_bundle;
  assign proto_err = proto_err_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      proto_err_q <= 1'b0;
    end else begin
      proto_err_q <= proto_err_d;
    end
  end

  owner_fifo #(
    .DEPTH (DEPTH),
    .PTR_W (PTR_W)
  ) u_owner_fifo (
    .clk          (clk),
    .reset        (reset),
    .push         (push),
    .push_owner   (push_owner),
    .push_discard (push_discard),
    .pop          (pop),
    .cancel_inst  (inst_cancel),
    .head_owner   (head_owner),
    .head_discard (head_discard),
    .count        (outstanding),
    .full         (fifo_full),
    .empty        (fifo_empty)
  );

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Bench for mem_req_arbiter: grant table, directed corner sequences and
// random traffic, all checked against a queue-based model of the owners.
module tb_mem_req_arbiter;

  localparam bit DATA_PRIO = 1'b1;
  localparam int DEPTH     = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        inst_req, inst_wr, inst_cancel;
  logic [1:0]  inst_size;
  logic [3:0]  inst_wstrb;
  logic [31:0] inst_addr, inst_wdata;
  logic        inst_addr_ok, inst_data_ok;
  logic [31:0] inst_rdata;
  logic        data_req, data_wr;
  logic [1:0]  data_size;
  logic [3:0]  data_wstrb;
  logic [31:0] data_addr, data_wdata;
  logic        data_addr_ok, data_data_ok;
  logic [31:0] data_rdata;
  logic        mem_req, mem_wr;
  logic [1:0]  mem_size;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_addr_ok, mem_data_ok;
  logic [31:0] mem_rdata;
  logic [2:0]  outstanding;
  logic        proto_err;

  always #5 clk = ~clk;

  mem_req_arbiter dut (
    .clk          (clk),
    .reset        (reset),
    .inst_req     (inst_req),
    .inst_wr      (inst_wr),
    .inst_size    (inst_size),
    .inst_wstrb   (inst_wstrb),
    .inst_addr    (inst_addr),
    .inst_wdata   (inst_wdata),
    .inst_addr_ok (inst_addr_ok),
    .inst_data_ok (inst_data_ok),
    .inst_rdata   (inst_rdata),
    .inst_cancel  (inst_cancel),
    .data_req     (data_req),
    .data_wr      (data_wr),
    .data_size    (data_size),
    .data_wstrb   (data_wstrb),
    .data_addr    (data_addr),
    .data_wdata   (data_wdata),
    .data_addr_ok (data_addr_ok),
    .data_data_ok (data_data_ok),
    .data_rdata   (data_rdata),
    .mem_req      (mem_req),
    .mem_wr       (mem_wr),
    .mem_size     (mem_size),
    .mem_wstrb    (mem_wstrb),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_addr_ok  (mem_addr_ok),
    .mem_data_ok  (mem_data_ok),
    .mem_rdata    (mem_rdata),
    .outstanding  (outstanding),
    .proto_err    (proto_err)
  );

  // Reference model: the list of outstanding requests in issue order.
  typedef struct {
    bit owner;    // 1 = data
    bit discard;
  } ent_t;

  ent_t q[$];
  bit   m_proto;
  bit   e_push, e_gd;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic clear_inputs();
    inst_req = 0; inst_wr = 0; inst_size = 2'd2; inst_wstrb = 4'hf;
    inst_addr = 0; inst_wdata = 0; inst_cancel = 0;
    data_req = 0; data_wr = 0; data_size = 2'd2; data_wstrb = 4'hf;
    data_addr = 0; data_wdata = 0;
    mem_addr_ok = 0; mem_data_ok = 0; mem_rdata = 0;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset = 1;
    @(posedge clk);
    #1;
    reset = 0;
    q.delete();
    m_proto = 0;
  endtask

  // Compare every output against the model at the falling edge.
  task automatic eval_cycle();
    bit full, gi, mreq, pop, iok, dok;
    @(negedge clk);
    full = (q.size() == DEPTH);
    e_gd = data_req && (DATA_PRIO || !inst_req);
    gi   = inst_req && !e_gd;
    mreq = (inst_req || data_req) && !full;
    e_push = mreq && mem_addr_ok;
    pop  = mem_data_ok && (q.size() > 0);
    iok  = pop && !q[0].owner && !q[0].discard;
    dok  = pop && q[0].owner;

    check("mem_req", mem_req, mreq);
    check("inst_addr_ok", inst_addr_ok, mem_addr_ok && mreq && gi);
    check("data_addr_ok", data_addr_ok, mem_addr_ok && mreq && e_gd);
    if (mreq) begin
      check("mem_addr", mem_addr, e_gd ? data_addr : inst_addr);
      check("mem_wdata", mem_wdata, e_gd ? data_wdata : inst_wdata);
      check("mem_ctrl", {mem_wr, mem_size, mem_wstrb},
            e_gd ? {data_wr, data_size, data_wstrb} : {inst_wr, inst_size, inst_wstrb});
    end else if (!inst_req && !data_req) begin
      check("mem_idle", {mem_addr, mem_wdata}, 64'd0);
      check("mem_idle_ctrl", {mem_wr, mem_size, mem_wstrb}, 0);
    end
    check("inst_data_ok", inst_data_ok, iok);
    check("data_data_ok", data_data_ok, dok);
    if (iok) check("inst_rdata", inst_rdata, mem_rdata);
    if (dok) check("data_rdata", data_rdata, mem_rdata);
    check("outstanding", outstanding, q.size());
    check("proto_err", proto_err, m_proto);
  endtask

  task automatic commit();
    @(posedge clk);
    if (mem_data_ok) begin
      if (q.size() > 0) void'(q.pop_front());
      else m_proto = 1;
    end
    if (inst_cancel) begin
      foreach (q[i]) if (!q[i].owner) q[i].discard = 1;
    end
    if (e_push) q.push_back('{owner: e_gd, discard: inst_cancel && !e_gd});
    #1;
  endtask

  task automatic step();
    eval_cycle();
    commit();
  endtask

  task automatic beat(input logic [31:0] rd);
    mem_data_ok = 1;
    mem_rdata   = rd;
  endtask

  typedef struct {
    bit ir, dr, aok;
    bit e_iaok, e_daok, e_mreq;
    int sel;      // 0 = idle payload, 1 = inst payload, 2 = data payload
    int e_out;
  } vec_t;

  vec_t tbl[7];

  initial begin
    logic [31:0] exp_addr;

    tbl[0] = '{ir: 0, dr: 0, aok: 1, e_iaok: 0, e_daok: 0, e_mreq: 0, sel: 0, e_out: 0};
    tbl[1] = '{ir: 1, dr: 0, aok: 1, e_iaok: 1, e_daok: 0, e_mreq: 1, sel: 1, e_out: 1};
    tbl[2] = '{ir: 0, dr: 1, aok: 1, e_iaok: 0, e_daok: 1, e_mreq: 1, sel: 2, e_out: 1};
    tbl[3] = '{ir: 1, dr: 1, aok: 1, e_iaok: 0, e_daok: 1, e_mreq: 1, sel: 2, e_out: 1};
    tbl[4] = '{ir: 1, dr: 1, aok: 0, e_iaok: 0, e_daok: 0, e_mreq: 1, sel: 2, e_out: 0};
    tbl[5] = '{ir: 1, dr: 0, aok: 0, e_iaok: 0, e_daok: 0, e_mreq: 1, sel: 1, e_out: 0};
    tbl[6] = '{ir: 0, dr: 1, aok: 0, e_iaok: 0, e_daok: 0, e_mreq: 1, sel: 2, e_out: 0};

    do_reset();
    check("reset_outstanding", outstanding, 0);
    check("reset_proto_err", proto_err, 0);
    check("reset_mem_req", mem_req, 0);

    // Grant/accept table, each vector from a freshly reset block.
    foreach (tbl[i]) begin
      do_reset();
      inst_req = tbl[i].ir; data_req = tbl[i].dr; mem_addr_ok = tbl[i].aok;
      inst_addr = 32'h1000 + 32'(i * 4); data_addr = 32'h8000 + 32'(i * 4);
      exp_addr = (tbl[i].sel == 2) ? data_addr : (tbl[i].sel == 1) ? inst_addr : 32'd0;
      eval_cycle();
      check("tbl_inst_addr_ok", inst_addr_ok, tbl[i].e_iaok);
      check("tbl_data_addr_ok", data_addr_ok, tbl[i].e_daok);
      check("tbl_mem_req", mem_req, tbl[i].e_mreq);
      check("tbl_mem_addr", mem_addr, exp_addr);
      commit();
      check("tbl_outstanding", outstanding, tbl[i].e_out);
    end

    // Simultaneous requests: data first, inst next cycle, responses in order.
    do_reset();
    inst_req = 1; data_req = 1; mem_addr_ok = 1;
    inst_addr = 32'h0000_1000; data_addr = 32'h0000_2000;
    eval_cycle();
    check("both_data_aok", data_addr_ok, 1);
    check("both_inst_aok", inst_addr_ok, 0);
    check("both_mem_addr", mem_addr, 32'h0000_2000);
    commit();
    data_req = 0;
    eval_cycle();
    check("second_inst_aok", inst_addr_ok, 1);
    check("second_mem_addr", mem_addr, 32'h0000_1000);
    commit();
    inst_req = 0; mem_addr_ok = 0;
    beat(32'h1111_1111);
    eval_cycle();
    check("resp1_data_ok", data_data_ok, 1);
    check("resp1_inst_ok", inst_data_ok, 0);
    check("resp1_rdata", data_rdata, 32'h1111_1111);
    commit();
    beat(32'h2222_2222);
    eval_cycle();
    check("resp2_inst_ok", inst_data_ok, 1);
    check("resp2_rdata", inst_rdata, 32'h2222_2222);
    commit();
    clear_inputs();

    // Fill to DEPTH, stall, one pop (not unblocking that cycle), then accept.
    do_reset();
    inst_req = 1; mem_addr_ok = 1;
    for (int k = 0; k < DEPTH; k++) begin
      inst_addr = 32'h4000 + 32'(k * 4);
      step();
    end
    inst_addr = 32'h4100;
    eval_cycle();
    check("full_outstanding", outstanding, 4);
    check("full_mem_req", mem_req, 0);
    check("full_inst_aok", inst_addr_ok, 0);
    commit();
    beat(32'h0000_00a5);
    eval_cycle();
    check("full_pop_aok", inst_addr_ok, 0);
    check("full_pop_ok", inst_data_ok, 1);
    commit();
    mem_data_ok = 0;
    eval_cycle();
    check("after_pop_outstanding", outstanding, 3);
    check("after_pop_aok", inst_addr_ok, 1);
    commit();
    inst_req = 0;
    for (int k = 0; k < DEPTH; k++) begin
      beat(32'h5000 + 32'(k));
      step();
    end
    clear_inputs();

    // Cancel: A and B flushed, C forwarded.
    do_reset();
    inst_req = 1; mem_addr_ok = 1;
    step(); step();
    inst_req = 0; inst_cancel = 1;
    step();
    inst_cancel = 0; inst_req = 1;
    step();
    inst_req = 0; mem_addr_ok = 0;
    beat(32'h0000_0aaa);
    eval_cycle(); check("cancel_beat1", inst_data_ok, 0); commit();
    beat(32'h0000_0bbb);
    eval_cycle(); check("cancel_beat2", inst_data_ok, 0); commit();
    beat(32'hcafe_f00d);
    eval_cycle();
    check("cancel_beat3", inst_data_ok, 1);
    check("cancel_beat3_rdata", inst_rdata, 32'hcafe_f00d);
    commit();
    clear_inputs();

    // data, inst, data with a cancel on the third issue.
    do_reset();
    mem_addr_ok = 1;
    data_req = 1; step();
    data_req = 0; inst_req = 1; step();
    inst_req = 0; data_req = 1; inst_cancel = 1; step();
    data_req = 0; inst_cancel = 0; mem_addr_ok = 0;
    beat(32'hdead_beef);
    eval_cycle();
    check("ld_data_ok", data_data_ok, 1);
    check("ld_rdata", data_rdata, 32'hdead_beef);
    check("ld_inst_ok", inst_data_ok, 0);
    commit();
    beat(32'h1234_5678);
    eval_cycle();
    check("flushed_inst_ok", inst_data_ok, 0);
    check("flushed_data_ok", data_data_ok, 0);
    commit();
    beat(32'h0bad_f00d);
    eval_cycle();
    check("ld2_data_ok", data_data_ok, 1);
    check("ld2_rdata", data_rdata, 32'h0bad_f00d);
    commit();
    clear_inputs();

    // Empty pop sets a sticky error; reset clears it.
    do_reset();
    beat(32'h0);
    eval_cycle();
    check("empty_inst_ok", inst_data_ok, 0);
    check("empty_data_ok", data_data_ok, 0);
    commit();
    mem_data_ok = 0;
    step(); step();
    check("proto_sticky", proto_err, 1);
    check("proto_outstanding", outstanding, 0);
    do_reset();
    check("proto_cleared", proto_err, 0);

    // Push and pop together at occupancy 2 across pointer wrap.
    inst_req = 1; mem_addr_ok = 1;
    step(); step();
    for (int k = 0; k < 8; k++) begin
      beat(32'h7000 + 32'(k));
      inst_addr = 32'h6000 + 32'(k * 4);
      eval_cycle();
      check("pp_outstanding", outstanding, 2);
      check("pp_inst_ok", inst_data_ok, 1);
      commit();
    end
    inst_req = 0; mem_addr_ok = 0;
    beat(32'h9);
    step(); step();
    mem_data_ok = 0;
    eval_cycle();
    check("pp_drained", outstanding, 0);
    commit();

    // Random traffic with a mid-run reset.
    for (int n = 0; n < 800; n++) begin
      if (n == 400) do_reset();
      inst_req    = ($urandom_range(0, 99) < 55);
      data_req    = ($urandom_range(0, 99) < 45);
      inst_wr     = 0;
      inst_size   = 2'($urandom_range(0, 2));
      inst_wstrb  = 4'($urandom);
      inst_addr   = $urandom;
      inst_wdata  = $urandom;
      data_wr     = 1'($urandom);
      data_size   = 2'($urandom_range(0, 2));
      data_wstrb  = 4'($urandom);
      data_addr   = $urandom;
      data_wdata  = $urandom;
      inst_cancel = ($urandom_range(0, 99) < 10);
      mem_addr_ok = ($urandom_range(0, 99) < 70);
      mem_data_ok = (q.size() > 0) ? ($urandom_range(0, 99) < 45)
                                   : ($urandom_range(0, 99) < 2);
      mem_rdata   = $urandom;
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
